spr_writeback_arbiter: RTL and testbench
========================================

// Module: spr_writeback_arbiter
// PURPOSE
//   Collects special-purpose-register results (XER, LR, CTR) from execution units and drives
//   the single SPR register-file write port (write_addr/enable/value/rs_id).
//   Each source has a small FIFO with valid/ready handshake; a round-robin arbiter retires
//   one result per cycle through registered outputs.
// PARAMETERS
//   SOURCES      2  number of result-producing units (>=2)
//   RS_ID_WIDTH  5  reservation-station ID width; must match the SPR register file
//   FIFO_DEPTH   2  entries per source FIFO; power of two, >=2
// PORTS
//   clk            in   1                  clock, all state updates on rising edge
//   rst            in   1                  synchronous, active-high reset
//   src_valid[s]   in   1 x SOURCES        source s presents a result
//   src_ready[s]   out  1 x SOURCES        source s FIFO can accept
//   src_addr[s]    in   [0:9] x SOURCES    SPR number (1=XER, 8=LR, 9=CTR)
//   src_value[s]   in   [0:31] x SOURCES   result value
//   src_rs_id[s]   in   [0:RS_ID_WIDTH-1]  producing reservation station ID
//   write_addr     out  [0:9]              to register-file write port
//   write_enable   out  1                  one-cycle write strobe
//   write_value    out  [0:31]             result value
//   write_rs_id    out  [0:RS_ID_WIDTH-1]  producer tag, compared by the register file
//   illegal_addr   out  1                  only with SPR_WB_ADDR_CHECK_EN
// BEHAVIOUR
//   - Reset: all FIFOs empty, rr_ptr=0, every output 0 (incl. src_ready) while rst=1.
//     Reset mid-operation discards all queued results; nothing is written afterwards.
//   - Accept: src_valid[s] && src_ready[s] at a rising edge pushes {addr,value,rs_id}.
//     src_ready[s] = !full[s]; no same-cycle pass-through on a full FIFO (push refused
//     even if that FIFO is popped in the same cycle). Per-source order is preserved.
//   - Arbitration (comb): search non-empty FIFOs from rr_ptr ascending, wrapping at
//     SOURCES; first hit k is granted and popped at the edge; rr_ptr <= (k+1) mod SOURCES.
//     No hit: rr_ptr holds, no pop.
//   - Output registers: on grant, next cycle write_enable=1 with head entry fields.
//     Otherwise write_enable=0 and write_addr/value/rs_id=0.
//   - Latency: accepted at edge N -> visible in cycle N+1 -> write_enable high in cycle N+2
//     (when uncontended). Throughput: 1 write/cycle aggregate.
//   - Fairness: with all sources continuously non-empty, grants rotate 0,1,..,SOURCES-1.
//   - Simultaneous push and pop on one FIFO (not full): both occur; count unchanged.
//   - FIFO pointers are log2(FIFO_DEPTH) bits with natural wrap; separate occupancy count
//     0..FIFO_DEPTH distinguishes full from empty.
//   - No filtering of rs_id: stale-tag rejection is the register file's job.
// CONFIGURATION
//   SPR_WB_ADDR_CHECK_EN defined: granted entry with addr not in {1,8,9} is popped and
//     consumes its arbitration slot, but write_enable stays 0 and illegal_addr pulses 1
//     for one cycle with the same timing a write would have; rr_ptr advances normally.
//   Not defined: illegal_addr port absent; every entry is forwarded unchanged.
// TESTING
//   1 Reset: rst=1 2 cycles -> all outputs 0, src_ready=0; after release src_ready=1.
//   2 Single: src0 push {8,0xDEADBEEF,3} at edge N -> cycle N+2 write_enable=1,
//     write_addr=8, write_value=0xDEADBEEF, write_rs_id=3; cycle N+3 write_enable=0.
//   3 Contention: src0 and src1 push same edge, rr_ptr=0 -> src0 written at N+2,
//     src1 at N+3; repeat with rr_ptr=1 -> src1 first.
//   4 Backpressure: FIFO_DEPTH=2, src1 stalled by continuous src0 traffic... push 2 to
//     src1 with arbiter idle disabled -> src_ready[1]=0 after 2 pushes; 3rd held until pop.
//   5 Order/wrap: 6 back-to-back pushes on src0 (values 1..6) -> writes in order 1..6.
//   6 Addr check (macro on): push addr=5 -> no write_enable, illegal_addr=1 at N+2;
//     macro off: write_addr=5 written at N+2.

Source files
------------

// File: rtl/spr_writeback_arbiter.sv
// SPR write-back arbiter: per-source result FIFOs, round-robin retirement into one registered SPR write port.
// Optional SPR_WB_ADDR_CHECK_EN: drops entries whose SPR number is not XER/LR/CTR and flags illegal_addr.
module spr_writeback_arbiter #(
  parameter int SOURCES     = 2,
  parameter int RS_ID_WIDTH = 5,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [SOURCES-1:0]             src_valid,
  output logic [SOURCES-1:0]             src_ready,
  input  logic [SOURCES*10-1:0]          src_addr,
  input  logic [SOURCES*32-1:0]          src_value,
  input  logic [SOURCES*RS_ID_WIDTH-1:0] src_rs_id,
  output logic [9:0]                     write_addr,
  output logic                           write_enable,
  output logic [31:0]                    write_value,
  output logic [RS_ID_WIDTH-1:0]         write_rs_id
`ifdef SPR_WB_ADDR_CHECK_EN
  ,
  output logic                           illegal_addr
`endif
);

  localparam int SRC_W = (SOURCES > 1) ? $clog2(SOURCES) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [9:0]             addr;
    logic [31:0]            value;
    logic [RS_ID_WIDTH-1:0] rs_id;
  } entry_t;

  entry_t           mem_q    [SOURCES][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [SOURCES];
  logic [PTR_W-1:0] rd_ptr_q [SOURCES];
  logic [CNT_W-1:0] cnt_q    [SOURCES];
  logic [CNT_W-1:0] cnt_d    [SOURCES];
  entry_t           entry_in [SOURCES];

  logic [SOURCES-1:0] push;
  logic [SOURCES-1:0] pop;
  logic               grant_vld;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  entry_t             head;

  logic                   wen_q, wen_d;
  logic [9:0]             waddr_q, waddr_d;
  logic [31:0]            wval_q, wval_d;
  logic [RS_ID_WIDTH-1:0] wrs_q, wrs_d;
`ifdef SPR_WB_ADDR_CHECK_EN
  logic                   ill_q, ill_d;
  logic                   addr_ok;
`endif

  // Ready is held low throughout reset; a full FIFO refuses pushes even when popped this cycle.
  always_comb begin
    for (int s = 0; s < SOURCES; s++) begin
      entry_in[s].addr  = src_addr[s*10 +: 10];
      entry_in[s].value = src_value[s*32 +: 32];
      entry_in[s].rs_id = src_rs_id[s*RS_ID_WIDTH +: RS_ID_WIDTH];
      src_ready[s]      = !rst && (cnt_q[s] != CNT_W'(FIFO_DEPTH));
      push[s]           = src_valid[s] && src_ready[s];
    end
  end

  always_comb begin
    int k;
    grant_vld = 1'b0;
    grant_idx = '0;
    k = 0;
    for (int i = 0; i < SOURCES; i++) begin
      k = int'(rr_ptr_q) + i;
      if (k >= SOURCES) k = k - SOURCES;
      if (!grant_vld && (cnt_q[SRC_W'(k)] != '0)) begin
        grant_vld = 1'b1;
        grant_idx = SRC_W'(k);
      end
    end
  end

  always_comb begin
    head = mem_q[grant_idx][rd_ptr_q[grant_idx]];
    for (int s = 0; s < SOURCES; s++) begin
      pop[s]   = grant_vld && (grant_idx == SRC_W'(s));
      cnt_d[s] = cnt_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
    end
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == SRC_W'(SOURCES - 1)) ? '0 : grant_idx + SRC_W'(1);
    end
  end

  always_comb begin
    wen_d   = 1'b0;
    waddr_d = '0;
    wval_d  = '0;
    wrs_d   = '0;
`ifdef SPR_WB_ADDR_CHECK_EN
    ill_d   = 1'b0;
    addr_ok = (head.addr == 10'd1) || (head.addr == 10'd8) || (head.addr == 10'd9);
    if (grant_vld) begin
      if (addr_ok) begin
        wen_d   = 1'b1;
        waddr_d = head.addr;
        wval_d  = head.value;
        wrs_d   = head.rs_id;
      end else begin
        ill_d = 1'b1;
      end
    end
`else
    if (grant_vld) begin
      wen_d   = 1'b1;
      waddr_d = head.addr;
      wval_d  = head.value;
      wrs_d   = head.rs_id;
    end
`endif
  end

  // Output registers are cleared in reset too, so the write port reads all-zero while rst is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wval_q   <= '0;
      wrs_q    <= '0;
`ifdef SPR_WB_ADDR_CHECK_EN
      ill_q    <= 1'b0;
`endif
      for (int s = 0; s < SOURCES; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wval_q   <= wval_d;
      wrs_q    <= wrs_d;
`ifdef SPR_WB_ADDR_CHECK_EN
      ill_q    <= ill_d;
`endif
      for (int s = 0; s < SOURCES; s++) begin
        if (push[s]) wr_ptr_q[s] <= wr_ptr_q[s] + PTR_W'(1);
        if (pop[s])  rd_ptr_q[s] <= rd_ptr_q[s] + PTR_W'(1);
        cnt_q[s] <= cnt_d[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < SOURCES; s++) begin
      if (push[s]) mem_q[s][wr_ptr_q[s]] <= entry_in[s];
    end
  end

  assign write_enable = wen_q;
  assign write_addr   = waddr_q;
  assign write_value  = wval_q;
  assign write_rs_id  = wrs_q;
`ifdef SPR_WB_ADDR_CHECK_EN
  assign illegal_addr = ill_q;
`endif

endmodule

// File: tb/tb_spr_writeback_arbiter.sv
// Bench for spr_writeback_arbiter: directed scenarios plus randomized traffic against a queue-based model.
// Honours SPR_WB_ADDR_CHECK_EN the same way the design does.
module tb_spr_writeback_arbiter;

  localparam int S  = 2;
  localparam int RS = 5;
  localparam int D  = 2;
  localparam int EW = 10 + 32 + RS;

  logic              clk = 1'b0;
  logic              rst;
  logic [S-1:0]      src_valid;
  logic [S-1:0]      src_ready;
  logic [S*10-1:0]   src_addr;
  logic [S*32-1:0]   src_value;
  logic [S*RS-1:0]   src_rs_id;
  logic [9:0]        write_addr;
  logic              write_enable;
  logic [31:0]       write_value;
  logic [RS-1:0]     write_rs_id;
`ifdef SPR_WB_ADDR_CHECK_EN
  logic              illegal_addr;
`endif

  logic [9:0]    a_in [S];
  logic [31:0]   v_in [S];
  logic [RS-1:0] r_in [S];

  always_comb begin
    for (int s = 0; s < S; s++) begin
      src_addr[s*10 +: 10]  = a_in[s];
      src_value[s*32 +: 32] = v_in[s];
      src_rs_id[s*RS +: RS] = r_in[s];
    end
  end

  spr_writeback_arbiter #(.SOURCES(S), .RS_ID_WIDTH(RS), .FIFO_DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_addr     (src_addr),
    .src_value    (src_value),
    .src_rs_id    (src_rs_id),
    .write_addr   (write_addr),
    .write_enable (write_enable),
    .write_value  (write_value),
    .write_rs_id  (write_rs_id)
`ifdef SPR_WB_ADDR_CHECK_EN
    ,
    .illegal_addr (illegal_addr)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one queue per source, a round-robin pointer and the expected write port.
  logic [EW-1:0] mq [S][$];
  int            rr;
  logic          e_wen, e_ill;
  logic [9:0]    e_addr;
  logic [31:0]   e_val;
  logic [RS-1:0] e_rs;
  logic [31:0]   seen [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int            sz [S];
    int            g;
    logic [EW-1:0] e;
    logic          legal;
    e_wen = 1'b0; e_ill = 1'b0; e_addr = '0; e_val = '0; e_rs = '0;
    if (rst) begin
      for (int s = 0; s < S; s++) mq[s].delete();
      rr = 0;
      return;
    end
    for (int s = 0; s < S; s++) sz[s] = mq[s].size();
    g = -1;
    for (int i = 0; i < S; i++) begin
      int k = (rr + i) % S;
      if (g < 0 && sz[k] > 0) g = k;
    end
    if (g >= 0) begin
      e = mq[g].pop_front();
      rr = (g + 1) % S;
      legal = (e[EW-1 -: 10] == 10'd1) || (e[EW-1 -: 10] == 10'd8) || (e[EW-1 -: 10] == 10'd9);
`ifdef SPR_WB_ADDR_CHECK_EN
      if (!legal) e_ill = 1'b1;
`else
      legal = 1'b1;
`endif
      if (legal) begin
        e_wen  = 1'b1;
        e_addr = e[EW-1 -: 10];
        e_val  = e[RS +: 32];
        e_rs   = e[RS-1:0];
      end
    end
    for (int s = 0; s < S; s++)
      if (src_valid[s] && sz[s] < D) mq[s].push_back({a_in[s], v_in[s], r_in[s]});
  endtask

  task automatic check_cycle();
    chk("write_enable", {63'd0, write_enable}, {63'd0, e_wen});
    chk("write_addr", {54'd0, write_addr}, {54'd0, e_addr});
    chk("write_value", {32'd0, write_value}, {32'd0, e_val});
    chk("write_rs_id", 64'(write_rs_id), 64'(e_rs));
`ifdef SPR_WB_ADDR_CHECK_EN
    chk("illegal_addr", {63'd0, illegal_addr}, {63'd0, e_ill});
`endif
    for (int s = 0; s < S; s++)
      chk("src_ready", {63'd0, src_ready[s]}, {63'd0, (!rst && mq[s].size() < D)});
    if (write_enable) seen.push_back(write_value);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic set_src(input int s, input logic v, input logic [9:0] a,
                         input logic [31:0] val, input logic [RS-1:0] r);
    src_valid[s] = v;
    a_in[s] = a;
    v_in[s] = val;
    r_in[s] = r;
  endtask

  task automatic idle();
    for (int s = 0; s < S; s++) set_src(s, 1'b0, '0, '0, '0);
  endtask

  initial begin
    logic          low_seen;
    logic [9:0]    addr_tbl [5];
    int            p;
    addr_tbl[0] = 10'd1; addr_tbl[1] = 10'd8; addr_tbl[2] = 10'd9;
    addr_tbl[3] = 10'd5; addr_tbl[4] = 10'd0;
    rst = 1'b1;
    idle();
    rr = 0;

    // Reset
    step(); step();
    chk("rst_wen", {63'd0, write_enable}, 64'd0);
    chk("rst_ready", {62'd0, src_ready}, 64'd0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", {62'd0, src_ready}, 64'd3);

    // Single transfer, two-cycle latency
    set_src(0, 1'b1, 10'd8, 32'hDEADBEEF, 5'd3);
    step();
    idle();
    chk("single_n1_wen", {63'd0, write_enable}, 64'd0);
    step();
    chk("single_wen", {63'd0, write_enable}, 64'd1);
    chk("single_addr", {54'd0, write_addr}, 64'd8);
    chk("single_value", {32'd0, write_value}, 64'hDEADBEEF);
    chk("single_rs", 64'(write_rs_id), 64'd3);
    step();
    chk("single_n3_wen", {63'd0, write_enable}, 64'd0);

    // Contention with pointer at 1 (source 0 was just granted)
    set_src(0, 1'b1, 10'd9, 32'hA0, 5'd1);
    set_src(1, 1'b1, 10'd9, 32'hA1, 5'd2);
    step(); idle();
    step();
    chk("cont_rr1_first", {32'd0, write_value}, 64'hA1);
    step();
    chk("cont_rr1_second", {32'd0, write_value}, 64'hA0);
    set_src(1, 1'b1, 10'd1, 32'hB1, 5'd4);
    step(); idle();
    step(); step();
    // Pointer now at 0
    set_src(0, 1'b1, 10'd8, 32'hC0, 5'd5);
    set_src(1, 1'b1, 10'd8, 32'hC1, 5'd6);
    step(); idle();
    step();
    chk("cont_rr0_first", {32'd0, write_value}, 64'hC0);
    step();
    chk("cont_rr0_second", {32'd0, write_value}, 64'hC1);
    step();

    // Backpressure: both sources pushing every cycle outrun the single write port
    low_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_src(0, 1'b1, 10'd8, 32'h100 + i, 5'(i));
      set_src(1, 1'b1, 10'd9, 32'h200 + i, 5'(i));
      step();
      if (!src_ready[1]) low_seen = 1'b1;
    end
    chk("bp_ready1_low", {63'd0, low_seen}, 64'd1);
    idle();
    for (int i = 0; i < 6; i++) step();

    // Order and pointer wrap on one source
    seen.delete();
    for (int i = 1; i <= 6; i++) begin
      set_src(0, 1'b1, 10'd9, 32'(i), 5'(i));
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) step();
    chk("order_count", 64'(seen.size()), 64'd6);
    for (int i = 0; i < 6 && i < seen.size(); i++)
      chk("order_value", {32'd0, seen[i]}, 64'(i + 1));

    // Non-architected SPR number
    set_src(0, 1'b1, 10'd5, 32'h55, 5'd7);
    step(); idle();
    step();
`ifdef SPR_WB_ADDR_CHECK_EN
    chk("addr5_wen", {63'd0, write_enable}, 64'd0);
    chk("addr5_illegal", {63'd0, illegal_addr}, 64'd1);
`else
    chk("addr5_wen", {63'd0, write_enable}, 64'd1);
    chk("addr5_addr", {54'd0, write_addr}, 64'd5);
`endif
    step();

    // Reset while results are queued discards them
    for (int i = 0; i < 3; i++) begin
      set_src(0, 1'b1, 10'd8, 32'h300 + i, 5'd1);
      set_src(1, 1'b1, 10'd1, 32'h400 + i, 5'd2);
      step();
    end
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_no_write", {63'd0, write_enable}, 64'd0);
    end

    // Randomized traffic with occasional reset
    for (int c = 0; c < 600; c++) begin
      for (int s = 0; s < S; s++) begin
        p = int'($urandom_range(0, 4));
        set_src(s, ($urandom_range(0, 99) < 60), addr_tbl[p], $urandom, 5'($urandom));
      end
      rst = ($urandom_range(0, 99) < 2);
      step();
    end
    rst = 1'b0;
    idle();
    for (int i = 0; i < 6; i++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
